// File: rtl/cordic_result_packer_if.sv
// Result-path bus between cordic and the processor result registers.
// Carries the fixed-point inputs, the quadrant count and the packed floats.
interface cordic_result_packer_if #(
    parameter int WIDTH = 32
);
    logic             valid_in;
    logic [WIDTH-1:0] sin_in;
    logic [WIDTH-1:0] cos_in;
    logic [2:0]       flips;
    logic [31:0]      sin_out;
    logic [31:0]      cos_out;
    logic             valid_out;
    logic             ready;

    modport master (
        output valid_in, sin_in, cos_in, flips,
        input  sin_out, cos_out, valid_out, ready
    );

    modport slave (
        input  valid_in, sin_in, cos_in, flips,
        output sin_out, cos_out, valid_out, ready
    );
endinterface

// File: rtl/cordic_result_packer.sv
// Undoes the quadrant reduction and packs sin/cos into IEEE-754 singles.
// Define ROUND_NEAREST_EN for round-to-nearest-even, else truncation.
module cordic_result_packer #(
    parameter int WIDTH     = 32,
    parameter int FRAC_BITS = 30
) (
    input logic                   clk,
    input logic                   rst,
    cordic_result_packer_if.slave bus
);
    localparam int PW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        IDLE, MAP, CONV_SIN, CONV_COS, DONE
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] sin_q, cos_q;
    logic [2:0]       flips_q;
    logic             sin_sgn, cos_sgn;
    logic [WIDTH-1:0] sin_mag, cos_mag;

    logic             s_neg, c_neg;
    logic [WIDTH-1:0] s_abs, c_abs;
    logic [1:0]       k;

    // Unsigned magnitude keeps -2^(WIDTH-1) exact.
    assign s_neg = sin_q[WIDTH-1];
    assign c_neg = cos_q[WIDTH-1];
    assign s_abs = s_neg ? -sin_q : sin_q;
    assign c_abs = c_neg ? -cos_q : cos_q;
    assign k     = 2'(-flips_q);

    logic             cv_sgn;
    logic [WIDTH-1:0] cv_mag, norm;
    logic [PW-1:0]    lead;
    logic [7:0]       cv_exp, res_exp;
    logic [22:0]      cv_man, res_man;
    logic [31:0]      cv_word;

    always_comb begin
        cv_sgn = (state == CONV_SIN) ? sin_sgn : cos_sgn;
        cv_mag = (state == CONV_SIN) ? sin_mag : cos_mag;
        lead   = '0;
        for (int i = 0; i < WIDTH; i++)
            if (cv_mag[i]) lead = PW'(i);
        norm   = cv_mag << (PW'(WIDTH - 1) - lead);
        cv_exp = 8'(int'(lead) - FRAC_BITS + 127);
        cv_man = norm[WIDTH-2 -: 23];
    end

`ifdef ROUND_NEAREST_EN
    localparam logic [WIDTH-1:0] LOW_MASK =
        WIDTH'((64'd1 << (WIDTH - 25)) - 64'd1);

    logic        rnd;
    logic [23:0] man_sum;

    always_comb begin
        rnd     = norm[WIDTH-25]
                & ((|(norm & LOW_MASK)) | cv_man[0]);
        man_sum = {1'b0, cv_man} + {23'd0, rnd};
        res_man = man_sum[22:0];
        res_exp = cv_exp + {7'd0, man_sum[23]};
    end
`else
    logic unused_norm;

    assign unused_norm = ^{norm[WIDTH-1], norm[WIDTH-25:0]};
    assign res_man     = cv_man;
    assign res_exp     = cv_exp;
`endif

    // Zero magnitude always packs as +0.0.
    assign cv_word = (cv_mag == '0) ? 32'h0
                                    : {cv_sgn, res_exp, res_man};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     if (bus.valid_in && bus.ready) state_nxt = MAP;
            MAP:      state_nxt = CONV_SIN;
            CONV_SIN: state_nxt = CONV_COS;
            CONV_COS: state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sin_q         <= '0;
            cos_q         <= '0;
            flips_q       <= '0;
            sin_sgn       <= 1'b0;
            cos_sgn       <= 1'b0;
            sin_mag       <= '0;
            cos_mag       <= '0;
            bus.sin_out   <= '0;
            bus.cos_out   <= '0;
            bus.valid_out <= 1'b0;
            bus.ready     <= 1'b1;
        end else begin
            bus.valid_out <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.valid_in && bus.ready) begin
                        sin_q     <= bus.sin_in;
                        cos_q     <= bus.cos_in;
                        flips_q   <= bus.flips;
                        bus.ready <= 1'b0;
                    end
                end
                MAP: begin
                    unique case (k)
                        2'd0: begin
                            sin_sgn <= s_neg;  sin_mag <= s_abs;
                            cos_sgn <= c_neg;  cos_mag <= c_abs;
                        end
                        2'd1: begin
                            sin_sgn <= c_neg;  sin_mag <= c_abs;
                            cos_sgn <= ~s_neg; cos_mag <= s_abs;
                        end
                        2'd2: begin
                            sin_sgn <= ~s_neg; sin_mag <= s_abs;
                            cos_sgn <= ~c_neg; cos_mag <= c_abs;
                        end
                        default: begin
                            sin_sgn <= ~c_neg; sin_mag <= c_abs;
                            cos_sgn <= s_neg;  cos_mag <= s_abs;
                        end
                    endcase
                end
                CONV_SIN: bus.sin_out <= cv_word;
                CONV_COS: bus.cos_out <= cv_word;
                DONE: begin
                    bus.valid_out <= 1'b1;
                    bus.ready     <= 1'b1;
                end
                default: bus.ready <= 1'b1;
            endcase
        end
    end
endmodule

// File: tb/tb_cordic_result_packer.sv
// Scoreboard bench for cordic_result_packer: angle-rotation and
// arithmetic float model, randomized and directed stimulus.
module tb_cordic_result_packer;
    localparam int WIDTH = 32;
    localparam int FRAC  = 30;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    typedef struct {
        logic [31:0] s;
        logic [31:0] c;
        int          acc;
    } exp_t;

    exp_t q[$];

    cordic_result_packer_if #(.WIDTH(WIDTH)) bus ();

    cordic_result_packer #(
        .WIDTH(WIDTH),
        .FRAC_BITS(FRAC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %08h required %08h", name, act, req);
        end
    endtask

    // Fixed-point integer to single, from the value itself.
    function automatic logic [31:0] to_float(input longint v);
        longint mag, m, rem, half;
        int     p;
        logic   sgn;
        if (v == 0) return 32'h0;
        sgn = (v < 0);
        mag = sgn ? -v : v;
        p = 0;
        while ((longint'(1) << (p + 1)) <= mag) p++;
        if (p >= 23) begin
            m   = mag >> (p - 23);
            rem = mag - (m << (p - 23));
        end else begin
            m   = mag << (23 - p);
            rem = 0;
        end
`ifdef ROUND_NEAREST_EN
        if (p >= 24) begin
            half = longint'(1) << (p - 24);
            if (rem > half || (rem == half && m[0])) m++;
        end
        if (m == (longint'(1) << 24)) begin
            m = m >> 1;
            p++;
        end
`else
        half = rem;
`endif
        return {sgn, 8'(p - FRAC + 127), 23'(m)};
    endfunction

    // original = reduced - 90deg * flips, applied one quarter turn at a time
    task automatic model(input logic [31:0] si, input logic [31:0] ci,
                         input logic [2:0] f,
                         output logic [31:0] so, output logic [31:0] co);
        longint s, c, t;
        int     n;
        s = longint'($signed(si));
        c = longint'($signed(ci));
        n = int'($signed(f));
        while (n > 0) begin
            t = s; s = -c; c = t; n--;
        end
        while (n < 0) begin
            t = s; s = c; c = -t; n++;
        end
        so = to_float(s);
        co = to_float(c);
    endtask

    task automatic send(input logic [31:0] s, input logic [31:0] c,
                        input logic [2:0] f, input logic [31:0] es,
                        input logic [31:0] ec);
        int guard = 0;
        @(negedge clk);
        while (bus.ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (bus.ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout: got ready=%b required 1", bus.ready);
        end else begin
            bus.valid_in = 1'b1;
            bus.sin_in   = s;
            bus.cos_in   = c;
            bus.flips    = f;
            q.push_back('{s: es, c: ec, acc: cyc + 1});
            @(negedge clk);
            bus.valid_in = 1'b0;
        end
    endtask

    task automatic send_model(input logic [31:0] s, input logic [31:0] c,
                              input logic [2:0] f);
        logic [31:0] es, ec;
        model(s, c, f, es, ec);
        send(s, c, f, es, ec);
    endtask

    task automatic drain();
        int guard = 0;
        while (q.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got pending=%0d required 0", q.size());
        end
    endtask

    function automatic logic [31:0] rnd_val();
        logic [31:0] tbl [6];
        tbl[0] = 32'h0000_0000;
        tbl[1] = 32'h8000_0000;
        tbl[2] = 32'h7FFF_FFFF;
        tbl[3] = 32'h4000_0000;
        tbl[4] = 32'h4000_00C0;
        tbl[5] = 32'hC000_0000;
        case ($urandom_range(0, 3))
            0: return tbl[$urandom_range(0, 5)];
            1: return 32'($urandom_range(1, 255));
            default: return 32'($urandom);
        endcase
    endfunction

    // Monitor: pops one expectation per valid_out pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.valid_out === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_valid_out: got valid_out=1 required 0");
                end else begin
                    e = q.pop_front();
                    check("sin_out", bus.sin_out, e.s);
                    check("cos_out", bus.cos_out, e.c);
                    check("latency", 32'(cyc - e.acc), 32'd4);
                    check("ready_at_valid", {31'd0, bus.ready}, 32'd1);
                end
            end
        end
    end

    initial begin
        int          last_acc;
        logic [31:0] es, ec, s, c;
        logic [2:0]  f;

        rst          = 1'b1;
        bus.valid_in = 1'b0;
        bus.sin_in   = '0;
        bus.cos_in   = '0;
        bus.flips    = '0;
        repeat (2) @(negedge clk);
        check("rst_sin_out", bus.sin_out, 32'h0);
        check("rst_cos_out", bus.cos_out, 32'h0);
        check("rst_valid_out", {31'd0, bus.valid_out}, 32'd0);
        check("rst_ready", {31'd0, bus.ready}, 32'd1);
        rst = 1'b0;

        send(32'h0000_0000, 32'h4000_0000, 3'd0, 32'h0000_0000, 32'h3F80_0000);
        send(32'h0000_0000, 32'h4000_0000, 3'b111, 32'h3F80_0000, 32'h0000_0000);
        send(32'h2000_0000, 32'hD000_0000, 3'd2, 32'hBF00_0000, 32'h3F40_0000);
        send(32'h8000_0000, 32'h2000_0000, 3'b101, 32'hBF00_0000, 32'hC000_0000);
`ifdef ROUND_NEAREST_EN
        send(32'h4000_00C0, 32'h0, 3'd0, 32'h3F80_0002, 32'h0);
        send(32'h7FFF_FFFF, 32'h0, 3'd0, 32'h4000_0000, 32'h0);
`else
        send(32'h4000_00C0, 32'h0, 3'd0, 32'h3F80_0001, 32'h0);
        send(32'h7FFF_FFFF, 32'h0, 3'd0, 32'h3FFF_FFFF, 32'h0);
`endif

        for (int i = 0; i < 40; i++) begin
            send_model(rnd_val(), rnd_val(), 3'($urandom));
            repeat ($urandom_range(0, 6)) @(negedge clk);
        end
        drain();

        // valid_in held high: accepts spaced 5 cycles, data in between ignored.
        last_acc = -1;
        for (int i = 0; i < 42; i++) begin
            @(negedge clk);
            s = rnd_val();
            c = rnd_val();
            f = 3'($urandom);
            bus.valid_in = 1'b1;
            bus.sin_in   = s;
            bus.cos_in   = c;
            bus.flips    = f;
            if (bus.ready === 1'b1) begin
                model(s, c, f, es, ec);
                q.push_back('{s: es, c: ec, acc: cyc + 1});
                if (last_acc >= 0)
                    check("accept_spacing", 32'(cyc + 1 - last_acc), 32'd5);
                last_acc = cyc + 1;
            end
        end
        @(negedge clk);
        bus.valid_in = 1'b0;
        drain();

        send_model(32'h4000_0000, 32'h2000_0000, 3'd0);
        drain();
        send(32'h1234_5678, 32'h4000_0000, 3'd1, 32'h0, 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        void'(q.pop_back());
        check("abort_sin_out", bus.sin_out, 32'h0);
        check("abort_cos_out", bus.cos_out, 32'h0);
        check("abort_valid_out", {31'd0, bus.valid_out}, 32'd0);
        check("abort_ready", {31'd0, bus.ready}, 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("post_abort_sin_out", bus.sin_out, 32'h0);

        send(32'h2000_0000, 32'hD000_0000, 3'd2, 32'hBF00_0000, 32'h3F40_0000);
        send_model(rnd_val(), rnd_val(), 3'($urandom));
        drain();
        repeat (3) @(negedge clk);
        check("queue_empty", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
